regfile_seq_clear: RTL and testbench

- Architectural register file for the single-cycle datapath: NUM_REGS x DATA_W storage, 2 combinational read ports, 1 synchronous write port.
- Each storage row is a 32-bit enabled register. A 5-to-32 write decoder drives the row enables, and two 32:1 read muxes drive the operand buses.
- Register ZERO_REG is hardwired to zero (XZR).
- A sequential clear engine, started by a request, zeroes every register, one register per cycle, and uses a busy/done handshake toward the control unit.

---
 rtl/regfile_seq_clear.sv | 126 ++++++++++++
 tb/tb_regfile_seq_clear.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_seq_clear.sv
// Architectural register file: two combinational read ports, one synchronous write
// port, a hardwired-zero register and a one-row-per-cycle clear engine.
module regfile_seq_clear #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  state_t              state;
  logic [ADDR_W-1:0]   clr_idx;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] row_we;
  logic [NUM_REGS-1:0] row_clr;
  logic                ext_wr_en;

  // An address names real storage only if it is in range and not the zero register.
  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    return (a != ZERO_ADDR) && ({1'b0, a} < (ADDR_W + 1)'(NUM_REGS));
  endfunction

  // The clear engine owns the write port while clearing; external writes are dropped.
  assign ext_wr_en = RegWrite && (state != CLEAR) && addr_valid(WriteRegister);

  // Row enable decoders for the external write and the clear engine.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    row_we  = '0;
    row_clr = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      row_we[r]  = ext_wr_en && (WriteRegister == ADDR_W'(r));
      row_clr[r] = (state == CLEAR) && (clr_idx == ADDR_W'(r)) && (r != ZERO_REG);
    end
  end

  // NOTE: this storage is built from flops, not RAM, because every row must clear on the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (row_clr[r])     regs[r] <= '0;
        else if (row_we[r]) regs[r] <= WriteData;
      end
    end
  end

  // Read muxes with same-cycle write forwarding; the bypass is off while clearing.
  always_comb begin
    ReadData1 = '0;
    if (addr_valid(ReadRegister1)) begin
      if (BYPASS && ext_wr_en && (WriteRegister == ReadRegister1)) ReadData1 = WriteData;
      else                                                          ReadData1 = regs[ReadRegister1];
    end
  end

  always_comb begin
    ReadData2 = '0;
    if (addr_valid(ReadRegister2)) begin
      if (BYPASS && ext_wr_en && (WriteRegister == ReadRegister2)) ReadData2 = WriteData;
      else                                                          ReadData2 = regs[ReadRegister2];
    end
  end

  // Clear engine sequencer; handshake outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      clr_idx  <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            clr_idx  <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) begin
            state    <= DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_seq_clear.sv
// Self-checking bench for regfile_seq_clear: directed steps followed by random traffic,
// all compared against a cycle-level behavioural model of the register file.
module tb_regfile_seq_clear;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int ZR = 31;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          RegWrite = 1'b0;
  logic [AW-1:0] WriteRegister = '0;
  logic [DW-1:0] WriteData = '0;
  logic [AW-1:0] ReadRegister1 = '0;
  logic [AW-1:0] ReadRegister2 = '0;
  logic [DW-1:0] ReadData1;
  logic [DW-1:0] ReadData2;
  logic          clr_req = 1'b0;
  logic          clr_busy;
  logic          clr_done;

  regfile_seq_clear dut (
    .clk          (clk),
    .rst          (rst),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .ReadRegister1(ReadRegister1),
    .ReadRegister2(ReadRegister2),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .clr_req      (clr_req),
    .clr_busy     (clr_busy),
    .clr_done     (clr_done)
  );

  always #5 clk = ~clk;

  // Model: register contents plus the position of an ongoing clear
  // (-1 = idle, 0..NR-1 = row about to be cleared, NR = the done cycle).
  logic [DW-1:0] mem [NR];
  int clr_pos = -1;
  int n_cmp   = 0;
  int n_mis   = 0;

  function automatic logic in_clear();
    return (clr_pos >= 0) && (clr_pos < NR);
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    if (int'(a) == ZR) return '0;
    if (RegWrite && !in_clear() && (WriteRegister == a)) return WriteData;
    return mem[a];
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk($sformatf("rd1[%0d]", ReadRegister1), ReadData1, exp_read(ReadRegister1));
    chk($sformatf("rd2[%0d]", ReadRegister2), ReadData2, exp_read(ReadRegister2));
    chk("clr_busy", 32'(clr_busy), 32'(in_clear()));
    chk("clr_done", 32'(clr_done), 32'(clr_pos == NR));
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) mem[r] = '0;
    clr_pos = -1;
  endtask

  // Advance one clock edge and apply the same edge to the model; returns at posedge+1.
  task automatic tick();
    logic          we  = RegWrite;
    logic [AW-1:0] wa  = WriteRegister;
    logic [DW-1:0] wd  = WriteData;
    logic          req = clr_req;
    @(posedge clk);
    #1;
    if (in_clear()) begin
      if (clr_pos != ZR) mem[clr_pos] = '0;
      clr_pos++;
    end else begin
      if (we && int'(wa) != ZR) mem[wa] = wd;
      if (clr_pos == NR) clr_pos = -1;
      else if (req)      clr_pos = 0;
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 64; i++) begin
      if (clr_done) break;
      check_all();
      tick();
    end
    chk(tag, 32'(clr_done), 32'd1);
    tick();
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    model_reset();

    // 1: reset state, all addresses on both ports
    #12;
    check_all();
    rst = 1'b1;
    tick();
    for (int a = 0; a < NR; a++) begin
      ReadRegister1 = AW'(a);
      ReadRegister2 = AW'(a);
      #1;
      check_all();
      chk("reset_zero", ReadData1 | ReadData2, '0);
      tick();
    end

    // 2: basic write and the hardwired zero register
    WriteRegister = 5'd5; WriteData = 32'hDEADBEEF; RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0; ReadRegister1 = 5'd5; ReadRegister2 = 5'd5;
    #1;
    check_all();
    chk("x5_p1", ReadData1, 32'hDEADBEEF);
    chk("x5_p2", ReadData2, 32'hDEADBEEF);
    WriteRegister = 5'd31; WriteData = 32'h12345678; RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0; ReadRegister1 = 5'd31;
    #1;
    check_all();
    chk("x31_zero", ReadData1, '0);

    // 3: same-cycle bypass, then the stored value
    tick();
    WriteRegister = 5'd7; WriteData = 32'hA5A5A5A5; RegWrite = 1'b1; ReadRegister2 = 5'd7;
    #1;
    check_all();
    chk("bypass", ReadData2, 32'hA5A5A5A5);
    tick();
    RegWrite = 1'b0;
    #1;
    check_all();
    chk("x7_stored", ReadData2, 32'hA5A5A5A5);

    // 4: fill X0..X30, one-cycle clear request, busy/done timing
    for (int i = 0; i < 31; i++) begin
      WriteRegister = AW'(i); WriteData = DW'(i + 1); RegWrite = 1'b1;
      tick();
    end
    RegWrite = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      ReadRegister1 = 5'd30;
      ReadRegister2 = AW'($urandom_range(0, NR - 1));
      #1;
      check_all();
      if (c == 30) chk("x30_before_clear", ReadData1, 32'd31);
      if (c == 31) chk("x30_after_clear", ReadData1, '0);
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      tick();
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd32);
    chk("done_cycles", 32'(done_cnt), 32'd1);
    for (int a = 0; a < NR; a++) begin
      ReadRegister1 = AW'(a);
      ReadRegister2 = AW'(NR - 1 - a);
      #1;
      check_all();
      chk("cleared", ReadData1 | ReadData2, '0);
      tick();
    end

    // 5: a write during CLEAR after its row was cleared is dropped
    WriteRegister = 5'd3; WriteData = 32'h33; RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (4) tick();
    WriteRegister = 5'd3; WriteData = 32'hFFFFFFFF; RegWrite = 1'b1; ReadRegister1 = 5'd3;
    #1;
    check_all();
    chk("no_bypass_in_clear", ReadData1, '0);
    tick();
    RegWrite = 1'b0;
    wait_done("done_seen_t5");
    ReadRegister1 = 5'd3;
    #1;
    check_all();
    chk("x3_dropped", ReadData1, '0);

    // 6: asynchronous reset in the middle of a clear
    WriteRegister = 5'd20; WriteData = 32'h55; RegWrite = 1'b1;
    tick();
    RegWrite = 1'b0; clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    ReadRegister1 = 5'd20;
    #1;
    check_all();
    chk("x20_mid_clear", ReadData1, 32'h55);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("x20_async_reset", ReadData1, '0);
    chk("busy_async_reset", 32'(clr_busy), '0);
    #2;
    rst = 1'b1;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    #1;
    check_all();
    chk("restart_busy", 32'(clr_busy), 32'd1);
    wait_done("done_seen_t6");

    // Random traffic with occasional clear requests
    for (int n = 0; n < 400; n++) begin
      RegWrite      = 1'($urandom_range(0, 1));
      WriteRegister = AW'($urandom_range(0, NR - 1));
      WriteData     = $urandom;
      ReadRegister1 = AW'($urandom_range(0, NR - 1));
      ReadRegister2 = ($urandom_range(0, 3) == 0) ? WriteRegister : AW'($urandom_range(0, NR - 1));
      clr_req       = ($urandom_range(0, 39) == 0);
      #1;
      check_all();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
